// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous programmable FIFO.
//   FIFO_DATA_W / FIFO_DEPTH : default word width and number of entries
//   calc_cnt_w()             : width of count/threshold signals for a depth
//   fifo_op_e                : per-cycle operation (NOP, WR, RD, WRRD), also
//                              used by the sequence items that drive the FIFO
package fifo_pkg;

  localparam int FIFO_DATA_W = 8;
  localparam int FIFO_DEPTH  = 16;

  // The count must hold the value DEPTH itself, so it needs one bit more
  // than the pointers do.
  function automatic int calc_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef enum logic [1:0] {
    FIFO_NOP  = 2'b00,
    FIFO_WR   = 2'b01,
    FIFO_RD   = 2'b10,
    FIFO_WRRD = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W simple dual-port register array.
//   clk     : write clock
//   wr_en   : write strobe, wr_data is stored at wr_addr on the rising edge
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address
//   rd_data : read data, combinational from rd_addr
// Contents are not reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int  DATA_W = FIFO_DATA_W,
  parameter int  DEPTH  = FIFO_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// occupancy count, sticky overflow/underflow flags and a read-valid strobe.
//   clk, rst       : clock (rising edge), asynchronous active-high reset
//   i_wren/i_wrdata: write request and data
//   i_rden         : read request (acknowledge of the presented word in FWFT)
//   i_afull_thr    : almost-full threshold  (o_alm_full  = count >= thr)
//   i_aempty_thr   : almost-empty threshold (o_alm_empty = count <= thr)
//   i_clr_err      : clears o_ovf/o_udf; a same-cycle set event wins
//   o_rddata/o_rdvalid : read data and its qualifier
//   o_count        : occupancy 0..DEPTH
//   o_full, o_alm_full, o_empty, o_alm_empty : status from the registered count
//   o_ovf, o_udf   : sticky overflow / underflow
// Build option: FIFO_FWFT_EN selects first-word fall-through; otherwise the
// read data is registered one cycle after an accepted read.
module fifo_sync_prog
  import fifo_pkg::*;
#(
  parameter int  DATA_W = FIFO_DATA_W,
  parameter int  DEPTH  = FIFO_DEPTH,
  localparam int CNT_W  = calc_cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wren,
  input  logic [DATA_W-1:0] i_wrdata,
  input  logic              i_rden,
  input  logic [CNT_W-1:0]  i_afull_thr,
  input  logic [CNT_W-1:0]  i_aempty_thr,
  input  logic              i_clr_err,
  output logic [DATA_W-1:0] o_rddata,
  output logic              o_rdvalid,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_full,
  output logic              o_alm_full,
  output logic              o_empty,
  output logic              o_alm_empty,
  output logic              o_ovf,
  output logic              o_udf
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] head_data;
  logic              rd_ok;
  logic              wr_ok;
  fifo_op_e          op;

  // Handshake: a request is accepted on the rising edge where it is high and
  // the FIFO can take it. Read: i_rden & ~o_empty. Write: i_wren & (~o_full |
  // read accepted same cycle), so a full FIFO can swap one word per cycle.
  // A rejected request changes no pointer or count; it only sets o_ovf/o_udf.
  always_comb begin
    rd_ok = i_rden & ~o_empty;
    wr_ok = i_wren & (~o_full | rd_ok);
    case ({rd_ok, wr_ok})
      2'b01:   op = FIFO_WR;
      2'b10:   op = FIFO_RD;
      2'b11:   op = FIFO_WRRD;
      default: op = FIFO_NOP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      case (op)
        FIFO_WR: count <= count + CNT_W'(1);
        FIFO_RD: count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign o_count     = count;
  assign o_full      = (count == CNT_W'(DEPTH));
  assign o_empty     = (count == '0);
  assign o_alm_full  = (count >= i_afull_thr);
  assign o_alm_empty = (count <= i_aempty_thr);

  // Sticky error flags: set has priority over clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_ovf <= 1'b0;
      o_udf <= 1'b0;
    end else begin
      if (i_wren && !wr_ok)  o_ovf <= 1'b1;
      else if (i_clr_err)    o_ovf <= 1'b0;
      if (i_rden && !rd_ok)  o_udf <= 1'b1;
      else if (i_clr_err)    o_udf <= 1'b0;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr),
    .wr_data (i_wrdata),
    .rd_addr (rd_ptr),
    .rd_data (head_data)
  );

`ifdef FIFO_FWFT_EN
  // Head entry is always presented; i_rden pops it on the edge.
  assign o_rddata  = head_data;
  assign o_rdvalid = ~o_empty;
`else
  logic [DATA_W-1:0] rddata_q;
  logic              rdvalid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rddata_q  <= '0;
      rdvalid_q <= 1'b0;
    end else begin
      rdvalid_q <= rd_ok;
      if (rd_ok) rddata_q <= head_data;
    end
  end

  assign o_rddata  = rddata_q;
  assign o_rdvalid = rdvalid_q;
`endif

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Directed bench for fifo_sync_prog (DATA_W=8, DEPTH=16, afull=14, aempty=2).
// A queue model tracks contents, acceptance, flags and expected read data.
module tb_fifo_sync_prog;
  import fifo_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = calc_cnt_w(DEPTH);
  localparam int AF_THR = 14;
  localparam int AE_THR = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              i_wren = 1'b0;
  logic [DATA_W-1:0] i_wrdata = '0;
  logic              i_rden = 1'b0;
  logic [CNT_W-1:0]  i_afull_thr = CNT_W'(AF_THR);
  logic [CNT_W-1:0]  i_aempty_thr = CNT_W'(AE_THR);
  logic              i_clr_err = 1'b0;
  logic [DATA_W-1:0] o_rddata;
  logic              o_rdvalid;
  logic [CNT_W-1:0]  o_count;
  logic              o_full, o_alm_full, o_empty, o_alm_empty, o_ovf, o_udf;

  fifo_sync_prog #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_wren       (i_wren),
    .i_wrdata     (i_wrdata),
    .i_rden       (i_rden),
    .i_afull_thr  (i_afull_thr),
    .i_aempty_thr (i_aempty_thr),
    .i_clr_err    (i_clr_err),
    .o_rddata     (o_rddata),
    .o_rdvalid    (o_rdvalid),
    .o_count      (o_count),
    .o_full       (o_full),
    .o_alm_full   (o_alm_full),
    .o_empty      (o_empty),
    .o_alm_empty  (o_alm_empty),
    .o_ovf        (o_ovf),
    .o_udf        (o_udf)
  );

  // ---------------- scoreboard ----------------
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_rddata = '0;
  logic              exp_ovf = 1'b0;
  logic              exp_udf = 1'b0;
  int                n_chk = 0;
  int                n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset();
    check("rst_count",  32'(o_count), 32'd0);
    check("rst_empty",  32'(o_empty), 32'd1);
    check("rst_aempty", 32'(o_alm_empty), 32'd1);
    check("rst_full",   32'(o_full), 32'd0);
    check("rst_afull",  32'(o_alm_full), 32'd0);
    check("rst_rdvalid",32'(o_rdvalid), 32'd0);
    check("rst_ovf",    32'(o_ovf), 32'd0);
    check("rst_udf",    32'(o_udf), 32'd0);
`ifndef FIFO_FWFT_EN
    check("rst_rddata", 32'(o_rddata), 32'd0);
`endif
  endtask

  task automatic check_status(input bit rd_ok);
    int cnt;
    cnt = exp_q.size();
    check("count",   32'(o_count), 32'(cnt));
    check("full",    32'(o_full), 32'(cnt == DEPTH));
    check("empty",   32'(o_empty), 32'(cnt == 0));
    check("afull",   32'(o_alm_full), 32'(cnt >= AF_THR));
    check("aempty",  32'(o_alm_empty), 32'(cnt <= AE_THR));
    check("ovf",     32'(o_ovf), 32'(exp_ovf));
    check("udf",     32'(o_udf), 32'(exp_udf));
`ifdef FIFO_FWFT_EN
    check("rdvalid", 32'(o_rdvalid), 32'(cnt > 0));
    if (cnt > 0) check("rddata", 32'(o_rddata), 32'(exp_q[0]));
`else
    check("rdvalid", 32'(o_rdvalid), 32'(rd_ok));
    check("rddata",  32'(o_rddata), 32'(exp_rddata));
`endif
  endtask

  // ---------------- driver ----------------
  // One clock of stimulus, then model update and full status check.
  task automatic op(input logic wr, input logic [DATA_W-1:0] d, input logic rd, input logic clr);
    bit rd_ok, wr_ok;
    rd_ok = rd && (exp_q.size() > 0);
    wr_ok = wr && ((exp_q.size() < DEPTH) || rd_ok);
    i_wren = wr; i_wrdata = d; i_rden = rd; i_clr_err = clr;
    step();
    i_wren = 1'b0; i_rden = 1'b0; i_clr_err = 1'b0;
    if (rd_ok) exp_rddata = exp_q.pop_front();
    if (wr_ok) exp_q.push_back(d);
    if (wr && !wr_ok) exp_ovf = 1'b1;
    else if (clr)     exp_ovf = 1'b0;
    if (rd && !rd_ok) exp_udf = 1'b1;
    else if (clr)     exp_udf = 1'b0;
    check_status(rd_ok);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) step();
    check_reset();
    rst = 1'b0;
    step();
    check_reset();

    // Fill 0x00..0x0F: aempty drops at 3, afull rises at 14, full at 16.
    for (int i = 0; i < DEPTH; i++) op(1'b1, DATA_W'(i), 1'b0, 1'b0);

    // Write into full FIFO is rejected and sets overflow; clear it.
    op(1'b1, 8'hAA, 1'b0, 1'b0);
    op(1'b0, 8'h00, 1'b0, 1'b1);

    // Full with read+write: count stays 16, 0x00 comes out, 0xBB goes in.
    op(1'b1, 8'hBB, 1'b1, 1'b0);
    // Drain to empty; the final word is 0xBB.
    for (int i = 0; i < DEPTH; i++) op(1'b0, 8'h00, 1'b1, 1'b0);
    op(1'b0, 8'h00, 1'b0, 1'b0);

    // Empty with read+write: read rejected (underflow), write accepted.
    op(1'b1, 8'h5A, 1'b1, 1'b0);
    op(1'b0, 8'h00, 1'b1, 1'b1);
    op(1'b0, 8'h00, 1'b0, 1'b0);

    // Three passes of 12 writes then 12 reads drive the pointers round.
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 12; i++) op(1'b1, DATA_W'(p * 32 + i + 1), 1'b0, 1'b0);
      for (int i = 0; i < 12; i++) op(1'b0, 8'h00, 1'b1, 1'b0);
    end

    // Set underflow, fill to 7, then assert reset between clock edges.
    op(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) op(1'b1, DATA_W'(8'hC0 + i), 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check_reset();
    step();
    rst = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    exp_rddata = '0;
    step();
    check_reset();

    // Stored data was discarded: fresh words come out in order.
    op(1'b1, 8'h11, 1'b0, 1'b0);
    op(1'b1, 8'h22, 1'b0, 1'b0);
    op(1'b0, 8'h00, 1'b1, 1'b0);
    op(1'b0, 8'h00, 1'b1, 1'b0);
    op(1'b0, 8'h00, 1'b0, 1'b0);

    // Single word into empty, then pop it (fall-through visibility in FWFT).
    op(1'b1, 8'h33, 1'b0, 1'b0);
    op(1'b0, 8'h00, 1'b1, 1'b0);
    op(1'b0, 8'h00, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
